// File: rtl/md_hazard_ctrl.sv
// md_hazard_ctrl: load-use / mult-div hazard detection and MD unit latency sequencing.
// Optional feature macro HAZ_STATS_EN adds a saturating stall-cycle counter (stall_cnt)
// and the md_stall perf-monitor output.
module md_hazard_ctrl #(
    parameter int MULT_CYC = 5,
    parameter int DIV_CYC  = 10,
    parameter int CNT_W    = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [4:0]  d_rs,
    input  logic [4:0]  d_rt,
    input  logic        d_use_rs,
    input  logic        d_use_rt,
    input  logic        d_is_md,
    input  logic        e_is_load,
    input  logic [4:0]  e_rt,
    input  logic        e_md_start,
    input  logic        e_md_div,
    output logic        pc_en,
    output logic        fd_en,
    output logic        idex_clr,
    output logic        md_busy,
    output logic        md_done,
`ifdef HAZ_STATS_EN
    output logic        md_kind,
    output logic [31:0] stall_cnt,
    output logic        md_stall
`else
    output logic        md_kind
`endif
);

    typedef enum logic {IDLE, BUSY} state_t;

    localparam logic [CNT_W-1:0] MULT_LD = CNT_W'(MULT_CYC - 1);
    localparam logic [CNT_W-1:0] DIV_LD  = CNT_W'(DIV_CYC - 1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             kind_q, kind_d;
    logic             load_use, md_hz, stall;

    // Next-state: any start (legal or not) reloads the unit; otherwise count down to completion
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        kind_d  = kind_q;
        if (e_md_start) begin
            state_d = BUSY;
            cnt_d   = e_md_div ? DIV_LD : MULT_LD;
            kind_d  = e_md_div;
        end else if (state_q == BUSY) begin
            if (cnt_q == '0)
                state_d = IDLE;
            else
                cnt_d = cnt_q - CNT_W'(1);
        end
    end

    // Unit state registers; async reset aborts any op in flight
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            kind_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            kind_q  <= kind_d;
        end
    end

    assign md_busy  = (state_q == BUSY);
    assign md_done  = (state_q == BUSY) && (cnt_q == '0);
    assign md_kind  = kind_q;

    assign load_use = e_is_load && (e_rt != 5'd0) &&
                      ((d_use_rs && (d_rs == e_rt)) || (d_use_rt && (d_rt == e_rt)));
    assign md_hz    = d_is_md && (md_busy || e_md_start);
    assign stall    = load_use || md_hz;

    assign pc_en    = !stall;
    assign fd_en    = !stall;
    assign idex_clr = stall;

`ifdef HAZ_STATS_EN
    logic [31:0] stall_cnt_q, stall_cnt_d;

    // Saturating count of stalled cycles
    always_comb stall_cnt_d = (stall && stall_cnt_q != 32'hFFFF_FFFF) ? stall_cnt_q + 32'd1 : stall_cnt_q;

    // Stall counter register, cleared by reset
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            stall_cnt_q <= '0;
        else
            stall_cnt_q <= stall_cnt_d;
    end

    assign stall_cnt = stall_cnt_q;
    assign md_stall  = md_hz;
`endif

endmodule

// File: tb/tb_md_hazard_ctrl.sv
// tb_md_hazard_ctrl: vector table, directed multi-cycle sequences and randomized model checks.
module tb_md_hazard_ctrl;

    logic clk = 1'b0;
    logic reset;
    logic [4:0] d_rs, d_rt, e_rt;
    logic d_use_rs, d_use_rt, d_is_md, e_is_load, e_md_start, e_md_div;
    logic pc_en, fd_en, idex_clr, md_busy, md_done, md_kind;
`ifdef HAZ_STATS_EN
    logic [31:0] stall_cnt;
    logic md_stall;
`endif

    int n_chk = 0;
    int n_fail = 0;

    md_hazard_ctrl dut (
        .clk(clk), .reset(reset),
        .d_rs(d_rs), .d_rt(d_rt), .d_use_rs(d_use_rs), .d_use_rt(d_use_rt),
        .d_is_md(d_is_md), .e_is_load(e_is_load), .e_rt(e_rt),
        .e_md_start(e_md_start), .e_md_div(e_md_div),
        .pc_en(pc_en), .fd_en(fd_en), .idex_clr(idex_clr),
        .md_busy(md_busy), .md_done(md_done),
`ifdef HAZ_STATS_EN
        .md_kind(md_kind), .stall_cnt(stall_cnt), .md_stall(md_stall)
`else
        .md_kind(md_kind)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [4:0] rs, rt, ert;
        logic urs, urt, md, ld, st;
        logic exp;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic [4:0] rs, rt, ert, input logic urs, urt, md, ld, st, dv);
        d_rs = rs; d_rt = rt; e_rt = ert; d_use_rs = urs; d_use_rt = urt;
        d_is_md = md; e_is_load = ld; e_md_start = st; e_md_div = dv;
    endtask

    task automatic idle();
        drive(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_stall(input string name, input logic exp);
        chk({name, ".pc_en"}, {31'd0, pc_en}, {31'd0, !exp});
        chk({name, ".fd_en"}, {31'd0, fd_en}, {31'd0, !exp});
        chk({name, ".idex_clr"}, {31'd0, idex_clr}, {31'd0, exp});
    endtask

    task automatic do_reset();
        idle();
        reset = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        next_cycle();
    endtask

    task automatic drain();
        int k;
        idle();
        k = 0;
        @(negedge clk);
        while (md_busy && k < 30) begin
            next_cycle();
            @(negedge clk);
            k++;
        end
        chk("drain_timeout", {31'd0, md_busy}, 32'd0);
        next_cycle();
    endtask

    vec_t vecs[10];

    initial begin
        int rem;
        logic mkind, e_lu, e_st, e_busy;

        vecs[0] = '{rs:5'd8,  rt:5'd0,  ert:5'd8,  urs:1, urt:0, md:0, ld:1, st:0, exp:1};
        vecs[1] = '{rs:5'd0,  rt:5'd0,  ert:5'd0,  urs:1, urt:1, md:0, ld:1, st:0, exp:0};
        vecs[2] = '{rs:5'd1,  rt:5'd9,  ert:5'd9,  urs:1, urt:1, md:0, ld:1, st:0, exp:1};
        vecs[3] = '{rs:5'd9,  rt:5'd3,  ert:5'd9,  urs:0, urt:1, md:0, ld:1, st:0, exp:0};
        vecs[4] = '{rs:5'd4,  rt:5'd6,  ert:5'd5,  urs:1, urt:1, md:0, ld:1, st:0, exp:0};
        vecs[5] = '{rs:5'd7,  rt:5'd7,  ert:5'd7,  urs:1, urt:1, md:0, ld:0, st:0, exp:0};
        vecs[6] = '{rs:5'd0,  rt:5'd0,  ert:5'd0,  urs:0, urt:0, md:1, ld:0, st:0, exp:0};
        vecs[7] = '{rs:5'd0,  rt:5'd0,  ert:5'd0,  urs:0, urt:0, md:1, ld:0, st:1, exp:1};
        vecs[8] = '{rs:5'd0,  rt:5'd0,  ert:5'd0,  urs:0, urt:0, md:0, ld:0, st:1, exp:0};
        vecs[9] = '{rs:5'd2,  rt:5'd31, ert:5'd31, urs:0, urt:1, md:0, ld:1, st:0, exp:1};

        idle();
        reset = 1'b0;
        #2;
        chk("rst.md_busy", {31'd0, md_busy}, 32'd0);
        chk("rst.md_done", {31'd0, md_done}, 32'd0);
        chk("rst.md_kind", {31'd0, md_kind}, 32'd0);
        chk_stall("rst", 1'b0);
        do_reset();

        // load-use: one-cycle stall, then the bubble releases it
        drive(5'd8, 5'd0, 5'd8, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        @(negedge clk);
        chk_stall("lu_hit", 1'b1);
        next_cycle();
        drive(5'd8, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        chk_stall("lu_bubble", 1'b0);
        next_cycle();
        drive(5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        @(negedge clk);
        chk_stall("lu_r0", 1'b0);
        next_cycle();

        // mult followed by mflo held in D
        for (int k = 0; k <= 6; k++) begin
            drive(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, k == 0, 1'b0);
            @(negedge clk);
            chk_stall($sformatf("mul_mflo[%0d]", k), k <= 5);
            chk($sformatf("mul_busy[%0d]", k), {31'd0, md_busy}, {31'd0, k >= 1 && k <= 5});
            chk($sformatf("mul_done[%0d]", k), {31'd0, md_done}, {31'd0, k == 5});
            next_cycle();
        end
        idle();
`ifdef HAZ_STATS_EN
        chk("stall_cnt", stall_cnt, 32'd7);
`endif

        // div latency and kind
        for (int k = 0; k <= 11; k++) begin
            drive(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, k == 0, 1'b1);
            @(negedge clk);
            chk($sformatf("div_busy[%0d]", k), {31'd0, md_busy}, {31'd0, k >= 1 && k <= 10});
            chk($sformatf("div_done[%0d]", k), {31'd0, md_done}, {31'd0, k == 10});
            if (k == 10) chk("div_kind", {31'd0, md_kind}, 32'd1);
            next_cycle();
        end

        // back-to-back: mult issued in the div's done cycle
        for (int k = 0; k <= 16; k++) begin
            drive(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, k == 0 || k == 10, k == 0);
            @(negedge clk);
            chk($sformatf("b2b_busy[%0d]", k), {31'd0, md_busy}, {31'd0, k >= 1 && k <= 15});
            chk($sformatf("b2b_done[%0d]", k), {31'd0, md_done}, {31'd0, k == 10 || k == 15});
            if (k >= 11 && k <= 15) chk($sformatf("b2b_kind[%0d]", k), {31'd0, md_kind}, 32'd0);
            next_cycle();
        end

        // combinational hazard table from idle
        for (int i = 0; i < 10; i++) begin
            drive(vecs[i].rs, vecs[i].rt, vecs[i].ert, vecs[i].urs, vecs[i].urt,
                  vecs[i].md, vecs[i].ld, vecs[i].st, 1'b0);
            @(negedge clk);
            chk_stall($sformatf("vec[%0d]", i), vecs[i].exp);
            next_cycle();
            if (vecs[i].st) drain();
        end

        // randomized against a remaining-cycles model
        do_reset();
        rem = 0;
        mkind = 1'b0;
        for (int i = 0; i < 400; i++) begin
            drive(5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                  1'($urandom), 1'($urandom), 1'($urandom_range(0, 2) == 0),
                  1'($urandom), 1'($urandom_range(0, 7) == 0), 1'($urandom));
            @(negedge clk);
            e_busy = rem > 0;
            e_lu = e_is_load && e_rt != 0 && ((d_use_rs && d_rs == e_rt) || (d_use_rt && d_rt == e_rt));
            e_st = e_lu || (d_is_md && (e_busy || e_md_start));
            chk_stall($sformatf("rnd[%0d]", i), e_st);
            chk($sformatf("rnd_busy[%0d]", i), {31'd0, md_busy}, {31'd0, e_busy});
            chk($sformatf("rnd_done[%0d]", i), {31'd0, md_done}, {31'd0, rem == 1});
            chk($sformatf("rnd_kind[%0d]", i), {31'd0, md_kind}, {31'd0, mkind});
            if (e_md_start) begin
                rem = e_md_div ? 10 : 5;
                mkind = e_md_div;
            end else if (rem > 0) begin
                rem--;
            end
            next_cycle();
        end
        drain();

        // reset mid-op aborts the op without md_done
        for (int k = 0; k < 2; k++) begin
            drive(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, k == 0, 1'b0);
            next_cycle();
        end
        idle();
        chk("mid_busy_pre", {31'd0, md_busy}, 32'd1);
        #1;
        reset = 1'b0;
        #1;
        chk("mid_busy_async", {31'd0, md_busy}, 32'd0);
        chk("mid_done_async", {31'd0, md_done}, 32'd0);
        chk_stall("mid_rst", 1'b0);
        @(negedge clk);
        reset = 1'b1;
        for (int k = 0; k < 20; k++) begin
            next_cycle();
            @(negedge clk);
            chk($sformatf("mid_done[%0d]", k), {31'd0, md_done}, 32'd0);
            chk($sformatf("mid_pc_en[%0d]", k), {31'd0, pc_en}, 32'd1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/md_hazard_ctrl.md
Name: md_hazard_ctrl

Overview:
- Pipeline hazard and sequencing controller for the 5-stage MIPS core.
- Drives PC / IF-ID enables and the ID/EX clear (IDEX_CLR) for the D→E pipeline register.
- Detects load-use hazards and sequences the multi-cycle mult/div unit with a latency counter FSM.
- Stalls any HI/LO-class instruction in D until the unit is free, and pulses the HI/LO write at completion.

Parameters:
MULT_CYC, 5, cycles mult/multu occupies unit (≥1)
DIV_CYC, 10, cycles div/divu occupies unit (≥1)
CNT_W, 4, counter width; must hold max(MULT_CYC,DIV_CYC)-1

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset
d_rs  in  5  rs field of instruction in D
d_rt  in  5  rt field of instruction in D
d_use_rs  in  1  D instruction reads rs in D/E
d_use_rt  in  1  D instruction reads rt in D/E
d_is_md  in  1  D is mult/multu/div/divu/mfhi/mflo/mthi/mtlo
e_is_load  in  1  E holds a load (lw/lh/lb…)
e_rt  in  5  destination rt of E-stage load
e_md_start  in  1  E holds mult/multu/div/divu (valid, not bubble)
e_md_div  in  1  with e_md_start: 1=div class, 0=mult class
pc_en  out  1  PC write enable
fd_en  out  1  IF/ID register enable
idex_clr  out  1  clear ID/EX register (insert bubble)
md_busy  out  1  unit occupied
md_done  out  1  one-cycle pulse: write HI/LO this cycle
md_kind  out  1  class of op in flight (1=div)

Behaviour:
- States: IDLE, BUSY. Registers: state, cnt[CNT_W-1:0], kind.
- Reset (reset=0, async): state=IDLE, cnt=0, kind=0 → md_busy=0, md_done=0, md_kind=0, pc_en=1, fd_en=1, idex_clr=0. An op in flight is aborted; no md_done is issued for it.
- IDLE, e_md_start=1: next edge → BUSY, cnt=(e_md_div?DIV_CYC:MULT_CYC)-1, kind=e_md_div.
- BUSY, cnt≠0: cnt decrements each edge.
- BUSY, cnt==0: next edge → IDLE, unless e_md_start=1, in which case BUSY is reloaded as from IDLE (back-to-back).
- BUSY, e_md_start=1 while cnt≠0: illegal under correct stalling. Required behaviour: reload counter and kind with the new op; the old op never produces md_done.
- Outputs:
  - md_busy = (state==BUSY).
  - md_done = (state==BUSY && cnt==0), combinational.
  - md_kind = kind.
- Timing: op in E in cycle t → md_busy high cycles t+1 … t+LAT; md_done high in cycle t+LAT only.
- Hazard terms (combinational, same cycle):
  - load_use = e_is_load & (e_rt≠0) & ((d_use_rs & d_rs==e_rt) | (d_use_rt & d_rt==e_rt)).
  - md_hz = d_is_md & (md_busy | e_md_start).
  - stall = load_use | md_hz.
- Stall outputs: pc_en = fd_en = ~stall; idex_clr = stall.
- A stalled D instruction re-evaluates every cycle.
- A bubble in E has e_is_load=0 and e_md_start=0, so a load-use stall lasts exactly 1 cycle.
- An MD stall releases in the cycle after md_done (state IDLE, e_md_start=0).
- Register $0 never causes a load-use stall.
- Reset deassertion takes effect at the next rising edge; no glitching of pc_en on deassertion.

Optional Feature:
- Macro HAZ_STATS_EN.
- When defined:
  - Extra output port stall_cnt (out, 32): counts cycles with stall=1.
  - Saturates at 32'hFFFFFFFF; cleared by reset.
  - Extra output md_stall (out, 1) = md_hz, for the perf monitor.
- When undefined: ports absent, no counter logic; all other behaviour identical.

Test Plan:
- Reset mid-op: mult starts at t, reset=0 at t+2 → md_busy=0 immediately (async); no md_done within next 20 cycles; pc_en=1.
- Load-use: e_is_load=1, e_rt=8, d_use_rs=1, d_rs=8 → pc_en=0, fd_en=0, idex_clr=1 for exactly 1 cycle. Same with e_rt=0 → no stall.
- Mult then mflo: e_md_start=1, e_md_div=0 at t; d_is_md=1 from t.
  - Required: stall high t … t+5.
  - md_busy high t+1 … t+5; md_done high only at t+5.
  - pc_en returns 1 at t+6.
- Div latency: e_md_start=1, e_md_div=1 at t → md_busy high 10 cycles; md_done at t+10 with md_kind=1.
- Back-to-back: second e_md_start (mult) in the md_done cycle of a div → state stays BUSY, cnt=4, md_kind=0; next md_done 5 cycles later.
- HAZ_STATS_EN: after the mult/mflo scenario plus one load-use stall → stall_cnt=7. Force the counter to 32'hFFFFFFFE, stall 3 cycles → stall_cnt=32'hFFFFFFFF.
